// File: rtl/branch_cond_unit.sv
// Registered branch-condition resolver: capture -> evaluate -> one-cycle result strobe.
// Define BRANCH_STATS_EN to add saturating evaluation/taken counters.
module branch_cond_unit #(
  parameter int NUM_COND = 4,
  parameter int SEL_W    = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_COND-1:0] cond_in,
  input  logic [SEL_W-1:0]    branch_sel,
  input  logic                negate,
  input  logic                eval,
  input  logic                flush,
  output logic                busy,
  output logic                valid,
  output logic                taken,
  output logic                pc_write_cond,
  output logic                sel_err,
  output logic [CNT_W-1:0]    eval_count,
  output logic [CNT_W-1:0]    taken_count
);

  localparam int SEL_N = 1 << SEL_W;

  typedef enum logic [1:0] {IDLE, LATCH, RESOLVE} state_t;

  state_t              state_q, state_d;
  logic [NUM_COND-1:0] cond_cap_q, cond_cap_d;
  logic [SEL_W-1:0]    sel_cap_q, sel_cap_d;
  logic                neg_cap_q, neg_cap_d;
  logic                res_q, res_d;
  logic                err_q, err_d;
  logic                valid_q, valid_d;
  logic                pcw_q, pcw_d;
  logic                taken_q, taken_d;
  logic                sel_err_q, sel_err_d;
  logic                capture;
  logic [SEL_N-1:0]    cond_pad;
  logic [SEL_N-1:0]    sel_ok;

  // Pad the flags to the full select range; unpopulated indices are flagged as errors.
  always_comb begin
    cond_pad = '0;
    sel_ok   = '0;
    for (int i = 0; i < NUM_COND; i++) begin
      cond_pad[i] = cond_cap_q[i];
      sel_ok[i]   = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    res_d     = res_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    pcw_d     = 1'b0;
    taken_d   = taken_q;
    sel_err_d = sel_err_q;
    case (state_q)
      IDLE: begin
        if (eval) begin
          capture = 1'b1;
          state_d = LATCH;
        end
      end
      LATCH: begin
        res_d   = sel_ok[sel_cap_q] & (cond_pad[sel_cap_q] ^ neg_cap_q);
        err_d   = ~sel_ok[sel_cap_q];
        state_d = RESOLVE;
      end
      RESOLVE: begin
        valid_d   = 1'b1;
        pcw_d     = res_q;
        taken_d   = res_q;
        sel_err_d = err_q;
        if (eval) begin
          capture = 1'b1;
          state_d = LATCH;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush abandons everything in flight, including a result about to be published.
    if (flush) begin
      state_d   = IDLE;
      capture   = 1'b0;
      valid_d   = 1'b0;
      pcw_d     = 1'b0;
      taken_d   = taken_q;
      sel_err_d = sel_err_q;
    end
    cond_cap_d = capture ? cond_in    : cond_cap_q;
    sel_cap_d  = capture ? branch_sel : sel_cap_q;
    neg_cap_d  = capture ? negate     : neg_cap_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      pcw_q     <= 1'b0;
      taken_q   <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      pcw_q     <= pcw_d;
      taken_q   <= taken_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Operand and result holding registers carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    cond_cap_q <= cond_cap_d;
    sel_cap_q  <= sel_cap_d;
    neg_cap_q  <= neg_cap_d;
    res_q      <= res_d;
    err_q      <= err_d;
  end

  assign busy          = (state_q == LATCH);
  assign valid         = valid_q;
  assign taken         = taken_q;
  assign pc_write_cond = pcw_q;
  assign sel_err       = sel_err_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] eval_count_q, eval_count_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // valid_d is high exactly on a non-flushed RESOLVE cycle.
  always_comb begin
    eval_count_d  = valid_d ? sat_inc(eval_count_q) : eval_count_q;
    taken_count_d = (valid_d & pcw_d) ? sat_inc(taken_count_q) : taken_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      eval_count_q  <= '0;
      taken_count_q <= '0;
    end else begin
      eval_count_q  <= eval_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign eval_count  = eval_count_q;
  assign taken_count = taken_count_q;
`else
  assign eval_count  = '0;
  assign taken_count = '0;
`endif

endmodule
